// File: rtl/i2c_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_arb_pkg
//  Purpose  : Shared types and constants for the I2C requester arbiter:
//             FSM state encoding, I2C frame width and ACK polarity.
//  Revision : 1.0 - initial release
// ============================================================================
package i2c_arb_pkg;

    // {slave address, sub-address, data} frame handed to the I2C controller
    localparam int I2C_FRAME_W = 24;

    // Controller ACK level that means the slave acknowledged the frame
    localparam logic I2C_ACK_OK = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_END = 2'd2,
        ST_RELEASE  = 2'd3
    } arb_state_e;

endpackage : i2c_arb_pkg
`default_nettype wire

// File: rtl/i2c_arb_sync.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_arb_sync
//  Purpose  : Two-flop synchronizer bringing the I2C controller's END/ACK
//             from the divided I2C control clock domain into iCLK.
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_arb_sync #(
    parameter int WIDTH = 1
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // First stage may go metastable; second stage gives it a cycle to settle
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : i2c_arb_sync
`default_nettype wire

// File: rtl/i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_req_arbiter
//  Purpose  : Round-robin sharing of one I2C controller between N_REQ
//             requesters, with per-transaction NACK retry and one-cycle
//             DONE/ERR reporting to the granted requester.
//  Options  : define I2C_ARB_TIMEOUT_EN to abort a transaction whose END
//             does not arrive within TIMEOUT_CYCLES of entering WAIT_END.
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ          = 3,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                         iCLK,
    input  logic                         iRST_N,
    input  logic [N_REQ-1:0]             iREQ,
    input  logic [I2C_FRAME_W*N_REQ-1:0] iREQ_DATA,
    output logic [N_REQ-1:0]             oGNT,
    output logic [N_REQ-1:0]             oDONE,
    output logic [N_REQ-1:0]             oERR,
    output logic                         oBUSY,
    output logic [I2C_FRAME_W-1:0]       oI2C_DATA,
    output logic                         oI2C_GO,
    input  logic                         iI2C_END,
    input  logic                         iI2C_ACK
);

    // ------------------------------------------------------------------------
    // Derived widths and sized constants
    // ------------------------------------------------------------------------
    localparam int PW = $clog2(N_REQ);
    // A zero-width counter is not legal, so MAX_RETRY=0 keeps one bit
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [PW-1:0] LAST_IDX  = PW'(N_REQ - 1);
    localparam logic [PW:0]   N_REQ_W   = (PW + 1)'(N_REQ);

    // Reject parameter sets the selection logic was not built for
    if (N_REQ < 2 || N_REQ > 8 || MAX_RETRY < 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("i2c_req_arbiter: unsupported parameter set");
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    arb_state_e             state_q, state_d;
    logic [N_REQ-1:0]       gnt_q,   gnt_d;
    logic [N_REQ-1:0]       done_q,  done_d;
    logic [N_REQ-1:0]       err_q,   err_d;
    logic [PW-1:0]          gidx_q,  gidx_d;
    logic [PW-1:0]          rr_q,    rr_d;
    logic [RW-1:0]          retry_q, retry_d;
    logic [I2C_FRAME_W-1:0] data_q,  data_d;
    logic                   go_q,    go_d;
    logic                   ack_q,   ack_d;

    logic                   end_s;
    logic                   ack_s;
    logic [I2C_FRAME_W-1:0] frame_w [N_REQ];
    logic [PW-1:0]          sel_w;
    logic [PW-1:0]          next_idx_w;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int              TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0]              cnt_q, cnt_d;
`endif

    // ------------------------------------------------------------------------
    // Controller handshake synchronizers
    // ------------------------------------------------------------------------
    i2c_arb_sync #(.WIDTH(1)) u_sync_end (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .d_i    (iI2C_END),
        .q_o    (end_s)
    );

    i2c_arb_sync #(.WIDTH(1)) u_sync_ack (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .d_i    (iI2C_ACK),
        .q_o    (ack_s)
    );

    // ------------------------------------------------------------------------
    // Requester frame unpacking: requester k owns bits [24k+23:24k]
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < N_REQ; k++) begin : g_frame
        assign frame_w[k] = iREQ_DATA[k*I2C_FRAME_W +: I2C_FRAME_W];
    end

    // ------------------------------------------------------------------------
    // Round-robin pick: first requester at or after ptr, ascending, wrapping.
    // When nothing is requesting the result is ptr; the FSM ignores it then.
    // ------------------------------------------------------------------------
    function automatic logic [PW-1:0] rr_select(
        input logic [N_REQ-1:0] req,
        input logic [PW-1:0]    ptr
    );
        logic [PW-1:0] sel;
        logic          found;
        logic [PW:0]   pos;
        sel   = ptr;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = {1'b0, ptr} + (PW + 1)'(i);
            if (pos >= N_REQ_W) begin
                pos = pos - N_REQ_W;
            end
            if (!found && req[pos[PW-1:0]]) begin
                sel   = pos[PW-1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign sel_w      = rr_select(iREQ, rr_q);
    // Priority moves to the requester after the one just served
    assign next_idx_w = (gidx_q == LAST_IDX) ? '0 : gidx_q + PW'(1);

    // ------------------------------------------------------------------------
    // Arbiter FSM: next state and registered outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = '0;
        gidx_d  = gidx_q;
        rr_d    = rr_q;
        retry_d = retry_q;
        data_d  = data_q;
        go_d    = go_q;
        ack_d   = ack_q;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (|iREQ) begin
                    gidx_d        = sel_w;
                    gnt_d         = '0;
                    gnt_d[sel_w]  = 1'b1;
                    data_d        = frame_w[sel_w];
                    retry_d       = '0;
                    state_d       = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                go_d    = 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = ST_WAIT_END;
            end

            ST_WAIT_END: begin
                if (end_s) begin
                    // ACK is only meaningful while END is high, so latch it now
                    ack_d   = ack_s;
                    go_d    = 1'b0;
                    state_d = ST_RELEASE;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    // A hung controller is not retried; release straight away
                    go_d          = 1'b0;
                    err_d[gidx_q] = 1'b1;
                    gnt_d         = '0;
                    rr_d          = next_idx_w;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
`endif
            end

            ST_RELEASE: begin
                // Wait until the controller has seen GO low before deciding
                if (!end_s) begin
                    if (ack_q == I2C_ACK_OK) begin
                        done_d[gidx_q] = 1'b1;
                        gnt_d          = '0;
                        rr_d           = next_idx_w;
                        state_d        = ST_IDLE;
                    end else if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + RW'(1);
                        state_d = ST_ISSUE;
                    end else begin
                        err_d[gidx_q] = 1'b1;
                        gnt_d         = '0;
                        rr_d          = next_idx_w;
                        state_d       = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                go_d    = 1'b0;
            end
        endcase
    end

    // State register; reset aborts any transaction without reporting it
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            gidx_q  <= '0;
            rr_q    <= '0;
            retry_q <= '0;
            data_q  <= '0;
            go_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            retry_q <= retry_d;
            data_q  <= data_d;
            go_q    <= go_d;
            ack_q   <= ack_d;
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    // Cycles spent in WAIT_END since the most recent GO assertion
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign oGNT      = gnt_q;
    assign oDONE     = done_q;
    assign oERR      = err_q;
    assign oBUSY     = (state_q != ST_IDLE);
    assign oI2C_DATA = data_q;
    assign oI2C_GO   = go_q;

endmodule : i2c_req_arbiter
`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_req_arbiter
//  Purpose  : Scoreboard bench for i2c_req_arbiter with a behavioural I2C
//             controller model (scripted ACK/NACK, optional hang).
//             The timeout scenario is built when I2C_ARB_TIMEOUT_EN is set.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_req_arbiter;

    localparam int N = 3;

    typedef struct {
        logic [N-1:0] gnt;
        logic [23:0]  data;
    } gnt_t;

    typedef struct {
        logic [N-1:0] done;
        logic [N-1:0] err;
        int           gos;
        int           lat;
    } resp_t;

    logic            iCLK = 1'b0;
    logic            iRST_N;
    logic [N-1:0]    iREQ;
    logic [24*N-1:0] iREQ_DATA;
    logic [N-1:0]    oGNT;
    logic [N-1:0]    oDONE;
    logic [N-1:0]    oERR;
    logic            oBUSY;
    logic [23:0]     oI2C_DATA;
    logic            oI2C_GO;
    logic            iI2C_END;
    logic            iI2C_ACK;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc      = 0;
    bit    hang     = 1'b0;
    logic  ack_script [$];
    gnt_t  exp_gnt    [$];
    resp_t exp_resp   [$];

    i2c_req_arbiter #(
        .N_REQ          (N),
        .MAX_RETRY      (3),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iREQ      (iREQ),
        .iREQ_DATA (iREQ_DATA),
        .oGNT      (oGNT),
        .oDONE     (oDONE),
        .oERR      (oERR),
        .oBUSY     (oBUSY),
        .oI2C_DATA (oI2C_DATA),
        .oI2C_GO   (oI2C_GO),
        .iI2C_END  (iI2C_END),
        .iI2C_ACK  (iI2C_ACK)
    );

    always #10 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Controller model: on GO, raise END with the next scripted ACK, then
    // drop END a couple of cycles after GO falls.
    initial begin
        int n;
        iI2C_END = 1'b0;
        iI2C_ACK = 1'b0;
        forever begin
            @(negedge iCLK);
            if (iRST_N && oI2C_GO) begin
                if (!hang) begin
                    repeat (3) @(negedge iCLK);
                    iI2C_ACK = (ack_script.size() > 0) ? ack_script.pop_front() : 1'b0;
                    iI2C_END = 1'b1;
                end
                n = 0;
                while (oI2C_GO && n < 5000) begin
                    @(negedge iCLK);
                    n++;
                end
                if (n >= 5000) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL model_go_low: GO still high after %0d cycles", n);
                end
                repeat (2) @(negedge iCLK);
                iI2C_END = 1'b0;
            end
        end
    end

    // Monitor: checks every grant and every DONE/ERR pulse against the queues
    logic [N-1:0] prev_gnt = '0;
    logic         prev_go  = 1'b0;
    int           go_cnt   = 0;
    int           go_cyc   = 0;
    always @(negedge iCLK) begin
        gnt_t  g;
        resp_t r;
        if (!iRST_N) begin
            prev_gnt = '0;
            prev_go  = 1'b0;
            go_cnt   = 0;
        end else begin
            if (oGNT != '0 && prev_gnt == '0) begin
                go_cnt = 0;
                if (exp_gnt.size() == 0) begin
                    check("unexpected_grant", {29'd0, oGNT}, 32'd0);
                end else begin
                    g = exp_gnt.pop_front();
                    check("grant_onehot", {29'd0, oGNT}, {29'd0, g.gnt});
                    check("grant_frame", {8'd0, oI2C_DATA}, {8'd0, g.data});
                end
            end
            if (prev_gnt != '0 && oGNT != '0) begin
                check("grant_held", {29'd0, oGNT}, {29'd0, prev_gnt});
            end
            if (oI2C_GO && !prev_go) begin
                go_cnt++;
                go_cyc = cyc;
            end
            if ((oDONE | oERR) != '0) begin
                if (exp_resp.size() == 0) begin
                    check("unexpected_resp", {26'd0, oDONE, oERR}, 32'd0);
                end else begin
                    r = exp_resp.pop_front();
                    check("resp_done", {29'd0, oDONE}, {29'd0, r.done});
                    check("resp_err", {29'd0, oERR}, {29'd0, r.err});
                    check("resp_gnt_before", {29'd0, prev_gnt}, {29'd0, r.done | r.err});
                    check("resp_gnt_cleared", {29'd0, oGNT}, 32'd0);
                    check("resp_go_pulses", go_cnt, r.gos);
                    if (r.lat >= 0) check("resp_latency", cyc - go_cyc, r.lat);
                end
            end
            prev_gnt = oGNT;
            prev_go  = oI2C_GO;
        end
    end

    task automatic wait_pulse(input string name);
        int n = 0;
        while ((oDONE | oERR) == '0 && n < 5000) begin
            @(negedge iCLK);
            n++;
        end
        if (n >= 5000) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: no DONE/ERR within 5000 cycles", name);
        end
    endtask

    initial begin
        iRST_N    = 1'b0;
        iREQ      = '0;
        iREQ_DATA = {24'h40_1234, 24'h34_021E, 24'h34_0C00};

        // Reset state
        repeat (3) @(negedge iCLK);
        check("rst_gnt", {29'd0, oGNT}, 32'd0);
        check("rst_done", {29'd0, oDONE}, 32'd0);
        check("rst_err", {29'd0, oERR}, 32'd0);
        check("rst_busy", {31'd0, oBUSY}, 32'd0);
        check("rst_data", {8'd0, oI2C_DATA}, 32'd0);
        check("rst_go", {31'd0, oI2C_GO}, 32'd0);
        iRST_N = 1'b1;
        repeat (5) @(negedge iCLK);
        check("idle_busy", {31'd0, oBUSY}, 32'd0);
        check("idle_gnt", {29'd0, oGNT}, 32'd0);

        // Single request, ACKed first time
        exp_gnt.push_back('{gnt: 3'b001, data: 24'h34_0C00});
        exp_resp.push_back('{done: 3'b001, err: 3'b000, gos: 1, lat: -1});
        iREQ = 3'b001;
        @(negedge iCLK);
        check("t1_gnt_latency", {29'd0, oGNT}, 32'd1);
        wait_pulse("t1_wait");
        iREQ = '0;
        @(negedge iCLK);
        check("t1_busy_low", {31'd0, oBUSY}, 32'd0);
        check("t1_go_low", {31'd0, oI2C_GO}, 32'd0);

        // Two NACKs then ACK on requester 2 (pointer now 1)
        ack_script = '{1'b1, 1'b1, 1'b0};
        exp_gnt.push_back('{gnt: 3'b100, data: 24'h40_1234});
        exp_resp.push_back('{done: 3'b100, err: 3'b000, gos: 3, lat: -1});
        iREQ = 3'b100;
        wait_pulse("t2_wait");
        iREQ = '0;
        @(negedge iCLK);
        check("t2_busy_low", {31'd0, oBUSY}, 32'd0);

        // Permanent NACK on requester 0: 1 + MAX_RETRY attempts then ERR
        ack_script = '{1'b1, 1'b1, 1'b1, 1'b1};
        exp_gnt.push_back('{gnt: 3'b001, data: 24'h34_0C00});
        exp_resp.push_back('{done: 3'b000, err: 3'b001, gos: 4, lat: -1});
        iREQ = 3'b001;
        wait_pulse("t3_wait");
        iREQ = '0;
        @(negedge iCLK);
        check("t3_gnt_low", {29'd0, oGNT}, 32'd0);

        // Reset in WAIT_END with pointer at 1: abort silently, pointer to 0
        hang = 1'b1;
        exp_gnt.push_back('{gnt: 3'b010, data: 24'h34_021E});
        iREQ = 3'b010;
        begin
            int n = 0;
            while (!oI2C_GO && n < 100) begin
                @(negedge iCLK);
                n++;
            end
            check("t4_go_seen", {31'd0, oI2C_GO}, 32'd1);
        end
        repeat (10) @(negedge iCLK);
        iRST_N = 1'b0;
        #1;
        check("t4_rst_go", {31'd0, oI2C_GO}, 32'd0);
        check("t4_rst_gnt", {29'd0, oGNT}, 32'd0);
        check("t4_rst_busy", {31'd0, oBUSY}, 32'd0);
        iREQ = '0;
        hang = 1'b0;
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (3) @(negedge iCLK);

        // Round robin with all three requesting, pointer restarted at 0
        iREQ_DATA = {24'h40_1234, 24'h34_021E, 24'h34_001E};
        for (int i = 0; i < 6; i++) begin
            logic [N-1:0] oh;
            logic [23:0]  fr;
            oh = 3'b001 << (i % 3);
            fr = iREQ_DATA[(i % 3)*24 +: 24];
            exp_gnt.push_back('{gnt: oh, data: fr});
            exp_resp.push_back('{done: oh, err: 3'b000, gos: 1, lat: -1});
        end
        iREQ = 3'b111;
        for (int i = 0; i < 6; i++) begin
            wait_pulse("t5_wait");
            if (i == 5) iREQ = '0;
            @(negedge iCLK);
        end
        check("t5_busy_low", {31'd0, oBUSY}, 32'd0);

`ifdef I2C_ARB_TIMEOUT_EN
        // Controller never ends: ERR 100 cycles after GO, no retry, next served
        hang = 1'b1;
        exp_gnt.push_back('{gnt: 3'b001, data: 24'h34_001E});
        exp_resp.push_back('{done: 3'b000, err: 3'b001, gos: 1, lat: 100});
        exp_gnt.push_back('{gnt: 3'b010, data: 24'h34_021E});
        exp_resp.push_back('{done: 3'b010, err: 3'b000, gos: 1, lat: -1});
        iREQ = 3'b011;
        wait_pulse("t6_wait_err");
        check("t6_go_dropped", {31'd0, oI2C_GO}, 32'd0);
        iREQ = 3'b010;
        hang = 1'b0;
        @(negedge iCLK);
        wait_pulse("t6_wait_done");
        iREQ = '0;
        @(negedge iCLK);
`endif

        repeat (5) @(negedge iCLK);
        check("left_exp_gnt", exp_gnt.size(), 32'd0);
        check("left_exp_resp", exp_resp.size(), 32'd0);
        check("left_ack_script", ack_script.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case something wedges outside the bounded waits
    initial begin
        #10ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule : tb_i2c_req_arbiter
`default_nettype wire

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
- Shares the single I2C controller, with its 24-bit {slave address, sub-address, data} frame and GO/END/ACK handshake, among N requesters.
- Typical requesters: audio codec boot config, video decoder boot config, runtime volume/input-select writers.
- Round-robin arbitration, per-transaction NACK retry and completion/error reporting per requester.
- Sits between the config/control logic and the I2C controller. Runs on the system clock and synchronizes the controller's END/ACK, which come from the divided I2C control clock domain.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- MAX_RETRY, 3, extra attempts after a NACK before reporting an error.
- TIMEOUT_CYCLES, 2000000, iCLK cycles allowed from GO assertion to END. Used only with I2C_ARB_TIMEOUT_EN.

Ports:
- iCLK  in  1  system clock, 50 MHz.
- iRST_N  in  1  reset, asynchronous, active-low.
- iREQ  in  N_REQ  per-requester request level.
- iREQ_DATA  in  24*N_REQ  per-requester frame. Requester k occupies bits [24k+23:24k].
- oGNT  out  N_REQ  one-hot grant, held for the whole transaction including retries.
- oDONE  out  N_REQ  one-cycle pulse: transaction ACKed.
- oERR  out  N_REQ  one-cycle pulse: retries exhausted or timeout.
- oBUSY  out  1  high whenever state is not IDLE.
- oI2C_DATA  out  24  frame to the controller, registered.
- oI2C_GO  out  1  GO to the controller, registered.
- iI2C_END  in  1  controller END, asynchronous to iCLK.
- iI2C_ACK  in  1  controller ACK. 0 = acknowledged, 1 = NACK. Asynchronous to iCLK.

Behaviour:
- Reset values: oGNT=0, oDONE=0, oERR=0, oBUSY=0, oI2C_DATA=0, oI2C_GO=0. Internal: RR pointer=0, retry count=0, state=IDLE.
- Reset is honoured mid-transaction: GO drops immediately, and no DONE/ERR is issued for the aborted transaction.
- END and ACK each pass through a 2-flop synchronizer. State decisions use only the synchronized values, giving 2 cycles of input latency.
- Requester rules:
  - Hold iREQ and its data stable until it sees its own oDONE or oERR.
  - Dropping iREQ while granted does not abort; the transaction completes and reports normally.
  - iREQ still high in the cycle after DONE/ERR counts as a new request.
- State machine:
  - IDLE: if any iREQ is set, select the first requester at or after the RR pointer (ascending index, wrapping). Register oGNT and latch that requester's frame into oI2C_DATA. Clear the retry count. Go to ISSUE. Grant appears 1 cycle after iREQ is sampled.
  - ISSUE: oI2C_GO<=1. Go to WAIT_END.
  - WAIT_END: wait for synchronized END=1. Then sample synchronized ACK, set oI2C_GO<=0 and go to RELEASE.
  - RELEASE: wait for synchronized END=0, so the controller has observed GO low. Then:
    - ACK=0: pulse oDONE[g], clear oGNT, set RR pointer to g+1 mod N_REQ, go to IDLE.
    - ACK=1 and retry count < MAX_RETRY: increment the count and go to ISSUE with the same frame.
    - Otherwise: pulse oERR[g], clear oGNT, advance the RR pointer as for DONE, go to IDLE.
- oDONE/oERR and the clearing of oGNT happen in the same cycle. The earliest re-arbitration is the following cycle, so there is no back-to-back grant within one cycle.
- Simultaneous requests are served in RR order. After serving requester g, the highest priority goes to g+1.
- oI2C_DATA is frozen while not IDLE. Changes on iREQ_DATA during a transaction have no effect.
- The retry count width is clog2(MAX_RETRY+1) and it saturates. With MAX_RETRY=0, the first NACK produces oERR.
- With no requests pending, the block stays in IDLE and all outputs remain at their reset values.

Optional Feature:
- Macro I2C_ARB_TIMEOUT_EN.
- Defined: a counter starts on entry to WAIT_END and counts iCLK cycles.
  - On reaching TIMEOUT_CYCLES: drop GO, pulse oERR[g], clear oGNT, advance the RR pointer, go to IDLE. The wait in RELEASE is skipped.
  - A timeout is never retried.
  - The counter clears on entry to every WAIT_END.
- Undefined: no counter logic; WAIT_END waits indefinitely.

Decomposition:
- Package i2c_arb_pkg:
  - state encoding IDLE/ISSUE/WAIT_END/RELEASE;
  - I2C_FRAME_W=24;
  - ACK polarity constant I2C_ACK_OK=0.
- One sub-module: i2c_arb_sync, a 2-flop synchronizer with async active-low reset and width parameter, instantiated for END and ACK.
- RR selection stays inline as a function.

Test Plan:
- Single request, N_REQ=3: iREQ=3'b001 with frame 24'h34_0C00; controller model ACKs (ACK=0) -> oGNT=001 one cycle later, oI2C_DATA=34_0C00, GO high; a single oDONE=001 pulse after END falls; oBUSY returns to 0.
- NACK retry: model returns ACK=1 twice, then 0 -> GO asserted 3 times with the same frame, oGNT held throughout, one oDONE, no oERR.
- Retries exhausted: ACK=1 always, MAX_RETRY=3 -> 4 GO pulses, then oERR pulse for the granted requester, oGNT=0.
- Round robin: iREQ=3'b111 held; each frame distinct (34_001E, 34_021E, 40_xxxx); all ACK -> grant order 0,1,2,0,1,2; each oDONE matches its frame.
- Reset mid-transaction: assert iRST_N=0 in WAIT_END -> GO=0, oGNT=0, no DONE/ERR; after release, the RR pointer restarts at 0.
- I2C_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=100: model never raises END -> GO drops and oERR pulses 100 cycles after entry to WAIT_END; no retry; next requester granted afterwards.
